rd_fifo_pixel_unpack: RTL and testbench

- Sits directly downstream of the frame-buffer read FIFO, in the rd_clk domain.
- Pops 32-bit words from the FIFO's prefetch (first-word-fall-through) read port and splits each word into two RGB565 pixels.
- Serves pixels on demand to the video timing/output stage, one pixel per pix_req, with a fixed 1-cycle latency.
- Counts pixels per frame and detects underflow; on underflow it optionally resynchronises the image.

---
 rtl/rd_fifo_pixel_unpack.sv | 153 +++++++++++++++
 tb/tb_rd_fifo_pixel_unpack.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_fifo_pixel_unpack.sv
// Unpacks 32-bit FWFT read-FIFO words into RGB565 pixels served on demand with 1-cycle latency.
// Optional macro UNDERFLOW_RESYNC_EN: discard late pixels after an underflow to keep screen alignment.
module rd_fifo_pixel_unpack #(
  parameter int          H_ACT           = 1280,
  parameter int          V_ACT           = 720,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800,
  parameter int          CNT_W           = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             frame_start,
  input  logic             fifo_rd_vld,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             pix_req,
  output logic             pix_vld,
  output logic [15:0]      pix_data,
  output logic             frame_done,
  output logic             underflow,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam int TOTAL = H_ACT * V_ACT;
  localparam int WORDS = TOTAL / 2;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0][15:0]  r_q, w_q_nxt;
  logic [2:0]        r_occ, w_occ_mid, w_occ_nxt;
  logic [CW-1:0]     r_words_fetched, r_pix_served;
  logic              r_pix_vld, r_underflow;
  logic [15:0]       r_pix_data;
  logic [CNT_W-1:0]  r_uf_cnt;
  logic              w_fetch_en, w_pop, w_serve, w_done_req, w_underflow_now;
  logic              w_drop0, w_drop1;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_en  = 1'b0;
    w_serve     = 1'b0;
    w_done_req  = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_fetch_en = fifo_rd_vld && (r_occ <= 3'd2) && (r_words_fetched < CW'(WORDS));
        w_serve    = pix_req;
        if (pix_req && (r_pix_served == CW'(TOTAL - 1))) w_state_nxt = S_DONE;
      end
      S_DONE:  w_done_req = pix_req;
      default: ;
    endcase
    // A new frame wins over any same-cycle pop or request.
    if (frame_start) begin
      w_state_nxt = S_ACTIVE;
      w_fetch_en  = 1'b0;
      w_serve     = 1'b0;
      w_done_req  = 1'b0;
    end
  end

  assign w_pop           = w_fetch_en;
  assign w_underflow_now = w_serve && (r_occ == 3'd0);

`ifdef UNDERFLOW_RESYNC_EN
  localparam int SKW = $clog2(TOTAL) + 1;
  logic [SKW-1:0] r_skip, w_skip_eff, w_skip_nxt;

  // An underflow this cycle makes the word arriving now already late.
  always_comb begin
    w_skip_eff = r_skip + SKW'(w_underflow_now);
    w_drop0    = w_pop && (w_skip_eff != '0);
    w_drop1    = w_pop && (w_skip_eff > SKW'(1));
    w_skip_nxt = w_skip_eff - SKW'(w_drop0) - SKW'(w_drop1);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)        r_skip <= '0;
    else if (frame_start) r_skip <= '0;
    else                  r_skip <= w_skip_nxt;
  end
`else
  assign w_drop0 = 1'b0;
  assign w_drop1 = 1'b0;
`endif

  // Queue update: head leaves on a serve, then surviving word pixels append in order.
  always_comb begin
    w_q_nxt   = r_q;
    w_occ_mid = r_occ;
    if (w_serve && (r_occ != 3'd0)) begin
      for (int i = 0; i < 3; i++) w_q_nxt[i] = r_q[i+1];
      w_occ_mid = r_occ - 3'd1;
    end
    w_occ_nxt = w_occ_mid;
    if (w_pop && !w_drop0) begin
      w_q_nxt[w_occ_nxt[1:0]] = fifo_rd_data[15:0];
      w_occ_nxt = w_occ_nxt + 3'd1;
    end
    if (w_pop && !w_drop1) begin
      w_q_nxt[w_occ_nxt[1:0]] = fifo_rd_data[31:16];
      w_occ_nxt = w_occ_nxt + 3'd1;
    end
  end

  // NOTE: queue payload needs no reset; r_occ alone decides which entries are live.
  always_ff @(posedge rd_clk) begin
    r_q <= w_q_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state         <= S_IDLE;
      r_occ           <= '0;
      r_words_fetched <= '0;
      r_pix_served    <= '0;
      r_pix_vld       <= 1'b0;
      r_pix_data      <= '0;
      r_underflow     <= 1'b0;
      r_uf_cnt        <= '0;
    end else if (frame_start) begin
      r_state         <= S_ACTIVE;
      r_occ           <= '0;
      r_words_fetched <= '0;
      r_pix_served    <= '0;
      r_pix_vld       <= 1'b0;
      r_underflow     <= 1'b0;
      r_uf_cnt        <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_occ     <= w_occ_nxt;
      r_pix_vld <= w_serve || w_done_req;
      if (w_pop)   r_words_fetched <= r_words_fetched + CW'(1);
      if (w_serve) r_pix_served    <= r_pix_served + CW'(1);
      if (w_serve)         r_pix_data <= (r_occ != 3'd0) ? r_q[0] : UNDERFLOW_COLOR;
      else if (w_done_req) r_pix_data <= UNDERFLOW_COLOR;
      if (w_underflow_now) begin
        r_underflow <= 1'b1;
        if (r_uf_cnt != '1) r_uf_cnt <= r_uf_cnt + CNT_W'(1);
      end
    end
  end

  assign fifo_rd_en    = w_fetch_en;
  assign pix_vld       = r_pix_vld;
  assign pix_data      = r_pix_data;
  assign frame_done    = (r_state == S_DONE);
  assign underflow     = r_underflow;
  assign underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_rd_fifo_pixel_unpack.sv
// Randomized self-checking bench for rd_fifo_pixel_unpack (H_ACT=4, V_ACT=2) against a queue-based model.
// Follows UNDERFLOW_RESYNC_EN the same way the design does.
module tb_rd_fifo_pixel_unpack;

  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          TOTAL = H * V;
  localparam int          WORDS = TOTAL / 2;
  localparam logic [15:0] UC    = 16'hF800;
`ifdef UNDERFLOW_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_ACT = 1, ST_DONE = 2;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        fifo_rd_vld = 1'b0;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        pix_req = 1'b0;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic        frame_done;
  logic        underflow;
  logic [15:0] underflow_cnt;

  rd_fifo_pixel_unpack #(.H_ACT(H), .V_ACT(V), .UNDERFLOW_COLOR(UC), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .pix_req(pix_req), .pix_vld(pix_vld), .pix_data(pix_data), .frame_done(frame_done),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Environment: FIFO contents offered to the DUT.
  logic [31:0] src[$];
  bit          vld_en = 1'b0;
  int          n_pops = 0;

  // Reference model: pixel queue, counts and skip budget straight from the behavioural rules.
  int          m_state;
  logic [15:0] m_q[$];
  int          m_words, m_served, m_skip, m_ufcnt;
  bit          m_uf, m_vld;
  logic [15:0] m_data;

  task automatic model_reset();
    m_state = ST_IDLE; m_q.delete(); m_words = 0; m_served = 0; m_skip = 0;
    m_ufcnt = 0; m_uf = 1'b0; m_vld = 1'b0; m_data = '0;
  endtask

  task automatic model_cycle(input bit fs, input bit req, input bit en, input logic [31:0] d);
    logic [15:0] pix;
    if (fs) begin
      m_q.delete(); m_words = 0; m_served = 0; m_skip = 0; m_ufcnt = 0;
      m_uf = 1'b0; m_vld = 1'b0; m_state = ST_ACT;
      return;
    end
    m_vld = 1'b0;
    if (m_state == ST_ACT) begin
      if (req) begin
        m_vld = 1'b1;
        m_served++;
        if (m_q.size() > 0) m_data = m_q.pop_front();
        else begin
          m_data = UC; m_uf = 1'b1;
          if (m_ufcnt < 65535) m_ufcnt++;
          if (RESYNC) m_skip++;
        end
        if (m_served == TOTAL) m_state = ST_DONE;
      end
      if (en) begin
        m_words++;
        for (int k = 0; k < 2; k++) begin
          pix = (k == 0) ? d[15:0] : d[31:16];
          if (RESYNC && m_skip > 0) m_skip--;
          else m_q.push_back(pix);
        end
      end
    end else if (m_state == ST_DONE && req) begin
      m_vld = 1'b1; m_data = UC;
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_pix_vld"}, pix_vld, m_vld);
    if (m_vld) check({pfx, "_pix_data"}, pix_data, m_data);
    check({pfx, "_frame_done"}, frame_done, m_state == ST_DONE);
    check({pfx, "_underflow"}, underflow, m_uf);
    check({pfx, "_underflow_cnt"}, underflow_cnt, m_ufcnt);
  endtask

  task automatic step(input bit fs, input bit req);
    bit exp_en, hs;
    @(negedge rd_clk);
    frame_start  = fs;
    pix_req      = req;
    fifo_rd_vld  = vld_en && (src.size() > 0);
    fifo_rd_data = (src.size() > 0) ? src[0] : $urandom();
    #1;
    exp_en = (m_state == ST_ACT) && !fs && fifo_rd_vld && (m_q.size() <= 2) && (m_words < WORDS);
    check("fifo_rd_en", fifo_rd_en, exp_en);
    hs = fifo_rd_en && fifo_rd_vld;
    model_cycle(fs, req, exp_en, fifo_rd_data);
    @(posedge rd_clk);
    if (hs) begin
      void'(src.pop_front());
      n_pops++;
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic load_fixed();
    src.delete();
    src.push_back(32'h2222_1111); src.push_back(32'h4444_3333);
    src.push_back(32'h6666_5555); src.push_back(32'h8888_7777);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_en"}, fifo_rd_en, 0);
    check({pfx, "_pix_vld"}, pix_vld, 0);
    check({pfx, "_pix_data"}, pix_data, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_underflow"}, underflow, 0);
    check({pfx, "_underflow_cnt"}, underflow_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // Requests while idle are ignored.
    step(0, 1);
    step(0, 1);

    // Fixed-data frame: one prefetch cycle, then 8 requests, then extra requests in DONE.
    load_fixed(); vld_en = 1'b1;
    step(1, 0);
    n_pops = 0;
    step(0, 0);
    for (int i = 0; i < 8; i++) step(0, 1);
    check("t1_frame_done", frame_done, 1);
    check("t1_underflow", underflow, 0);
    check("t1_pops", n_pops, 4);
    step(0, 1);
    check("t5_done_color", pix_data, UC);
    check("t5_ufcnt", underflow_cnt, 0);
    step(0, 0);

    // Continuous requests: pops throttled by occupancy, stop after the 4th word.
    load_fixed();
    step(1, 0);
    n_pops = 0;
    step(0, 0);
    for (int i = 0; i < 11; i++) step(0, 1);
    check("t2_pops", n_pops, 4);

    // Underflow at frame start, then the data arrives.
    load_fixed(); vld_en = 1'b0;
    step(1, 0);
    step(0, 1);
    step(0, 1);
    check("t3_ufcnt", underflow_cnt, 2);
    vld_en = 1'b1;
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 6; i++) step(0, 1);
    check("t3_done", frame_done, 1);

    // frame_start coincident with the 3rd request and a valid FIFO word.
    load_fixed();
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    step(1, 1);
    check("t4_no_vld", pix_vld, 0);
    for (int i = 0; i < 4; i++) src.push_back($urandom());
    step(0, 0);
    for (int i = 0; i < 8; i++) step(0, 1);

    // Reset mid-frame with three pixels buffered.
    load_fixed();
    step(1, 0);
    step(0, 0);
    step(0, 1);
    #2;
    rd_rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6");
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1);

    // Randomized frames: random FIFO availability, requests and occasional restarts.
    for (int f = 0; f < 12; f++) begin
      int done_cycles;
      src.delete();
      for (int i = 0; i < 6; i++) src.push_back($urandom());
      vld_en = 1'b1;
      step(1, 0);
      done_cycles = 0;
      for (int c = 0; c < 80 && done_cycles < 3; c++) begin
        vld_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) begin
          src.delete();
          for (int i = 0; i < 6; i++) src.push_back($urandom());
          step(1, $urandom_range(0, 1));
        end else begin
          step(0, $urandom_range(0, 1));
        end
        if (m_state == ST_DONE) done_cycles++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
